// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, datapath mux
// selects, ALU operations and the opcodes the decoder recognises.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LINK,
    S_LUI,
    S_AUIPC,
    S_ILLEGAL
  } state_e;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7b5 to an ALU operation for register and immediate ALU ops.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (funct3)
      // Immediate adds carry immediate bits in Instr[30], so SUB is R-type only.
      3'b000:  alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_control = ALU_SLL;
      3'b010:  alu_control = ALU_SLT;
      3'b011:  alu_control = ALU_SLTU;
      3'b100:  alu_control = ALU_XOR;
      3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_control = ALU_OR;
      3'b111:  alu_control = ALU_AND;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RV32I datapath.
// Define ILLEGAL_HALT_EN to halt on unsupported opcodes; otherwise they are one-cycle no-ops.
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       PCWrite,
  output logic       AddrSrc,
  output logic       JALR_LSB,
  output logic       illegal
);

  state_e     state;
  state_e     nxt;
  logic       is_store;
  logic       is_rtype;
  logic [3:0] alu_dec;

  assign is_rtype = (state == S_EXECR);

  alu_decoder u_alu_decoder (
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .is_rtype    (is_rtype),
    .alu_control (alu_dec)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: nxt = S_MEMADR;
          OP_RTYPE:          nxt = S_EXECR;
          OP_ITYPE:          nxt = S_EXECI;
          OP_BRANCH:         nxt = (funct3[2:1] == 2'b01) ? S_ILLEGAL : S_BRANCH;
          OP_JAL:            nxt = S_JAL;
          OP_JALR:           nxt = S_JALR;
          OP_LUI:            nxt = S_LUI;
          OP_AUIPC:          nxt = S_AUIPC;
          default:           nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   nxt = is_store ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  nxt = S_MEMWB;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: nxt = S_FETCH;
      S_EXECR:    nxt = S_ALUWB;
      S_EXECI:    nxt = S_ALUWB;
      S_ALUWB:    nxt = S_FETCH;
      S_BRANCH:   nxt = S_FETCH;
      S_JAL:      nxt = S_ALUWB;
      S_JALR:     nxt = S_LINK;
      S_LINK:     nxt = S_FETCH;
      S_LUI:      nxt = S_ALUWB;
      S_AUIPC:    nxt = S_ALUWB;
`ifdef ILLEGAL_HALT_EN
      S_ILLEGAL:  nxt = S_ILLEGAL;
`else
      S_ILLEGAL:  nxt = S_FETCH;
`endif
      default:    nxt = S_FETCH;
    endcase
  end

  // Load/store is latched in DECODE so later opcode changes cannot redirect MEMADR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      is_store <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_DECODE)
        is_store <= (opcode == OP_STORE);
    end
  end

  always_comb begin
    ImmSrc     = IMM_I;
    ALUControl = ALU_ADD;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_WD;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    PCWrite    = 1'b0;
    AddrSrc    = 1'b0;
    JALR_LSB   = 1'b0;
    case (state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        PCWrite   = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (opcode == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = is_store ? IMM_S : IMM_I;
      end
      S_MEMREAD:  AddrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AddrSrc  = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_A;
        ALUControl = alu_dec;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        ALUControl = alu_dec;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = SRCA_A;
        ALUControl = (funct3[2:1] == 2'b00) ? ALU_SUB :
                     (funct3[2:1] == 2'b10) ? ALU_SLT : ALU_SLTU;
        // beq/bge/bgeu take the branch on Zero, bne/blt/bltu on its complement.
        PCWrite    = Zero ^ (funct3[2] ^ funct3[0]);
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      S_JALR: begin
        ALUSrcA   = SRCA_A;
        ALUSrcB   = SRCB_IMM;
        JALR_LSB  = 1'b1;
        ResultSrc = RES_ALURESULT;
        PCWrite   = 1'b1;
      end
      S_LINK: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        RegWrite  = 1'b1;
      end
      S_LUI: begin
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = IMM_U;
        ALUControl = ALU_PASSB;
      end
      S_AUIPC: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_U;
      end
      default: ;
    endcase
    // Reset parks the FSM in FETCH; its write strobes must stay quiet until release.
    if (rst) begin
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      PCWrite  = 1'b0;
    end
  end

`ifdef ILLEGAL_HALT_EN
  assign illegal = (state == S_ILLEGAL);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; outputs sampled on the falling clock edge.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic       IRWrite, RegWrite, MemWrite, PCWrite, AddrSrc, JALR_LSB, illegal;

  int total = 0;
  int bad   = 0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .PCWrite(PCWrite), .AddrSrc(AddrSrc), .JALR_LSB(JALR_LSB),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [31:0] ins);
    opcode   = ins[6:0];
    funct3   = ins[14:12];
    funct7b5 = ins[30];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Starts at a FETCH sample; counts cycles until the next FETCH.
  task automatic count_cycles(input string tag, input logic [31:0] ins, input int exp);
    int n;
    set_instr(ins);
    n = 1;
    step();
    while (!IRWrite && n < 20) begin
      step();
      n++;
    end
    chk(tag, n, exp);
  endtask

  initial begin
    // reset state
    @(negedge clk);
    chk("rst_pcwrite", PCWrite, 0);
    chk("rst_irwrite", IRWrite, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_srcb", ALUSrcB, 2'b10);
    rst = 1'b0;
    #1;

    // R-type SUB walk-through
    set_instr({1'b0, 1'b1, 23'd0, 7'b0110011});
    funct3 = 3'b000;
    chk("fetch_ir", IRWrite, 1);
    chk("fetch_pcw", PCWrite, 1);
    chk("fetch_res", ResultSrc, 2'b10);
    chk("fetch_srca", ALUSrcA, 2'b00);
    step();
    chk("dec_srca", ALUSrcA, 2'b01);
    chk("dec_srcb", ALUSrcB, 2'b01);
    chk("dec_imm", ImmSrc, 3'b010);
    chk("dec_ir", IRWrite, 0);
    step();
    chk("execr_alu", ALUControl, 4'b0001);
    chk("execr_srca", ALUSrcA, 2'b10);
    chk("execr_rw", RegWrite, 0);
    step();
    chk("aluwb_rw", RegWrite, 1);
    chk("aluwb_res", ResultSrc, 2'b00);
    step();
    chk("r_fetch5", IRWrite, 1);

    // lw with opcode disturbed after DECODE
    set_instr(32'h0080A283);
    step();
    step();
    chk("memadr_imm", ImmSrc, 3'b000);
    chk("memadr_srcb", ALUSrcB, 2'b01);
    opcode = 7'b0100011;
    step();
    chk("memrd_addr", AddrSrc, 1);
    chk("memrd_mw", MemWrite, 0);
    step();
    chk("memwb_res", ResultSrc, 2'b01);
    chk("memwb_rw", RegWrite, 1);
    chk("memwb_mw", MemWrite, 0);
    step();
    chk("lw_fetch", IRWrite, 1);

    // beq / bne taken and not taken
    set_instr(32'h00208463);
    Zero = 1'b1;
    step();
    step();
    chk("beq_alu", ALUControl, 4'b0001);
    chk("beq_z1", PCWrite, 1);
    Zero = 1'b0;
    #1;
    chk("beq_z0", PCWrite, 0);
    step();
    set_instr(32'h00209463);
    step();
    step();
    chk("bne_z0", PCWrite, 1);
    Zero = 1'b1;
    #1;
    chk("bne_z1", PCWrite, 0);
    step();

    // blt and bgeu: operation and polarity
    opcode = 7'b1100011; funct3 = 3'b100; Zero = 1'b0;
    step();
    step();
    chk("blt_alu", ALUControl, 4'b0101);
    chk("blt_pcw", PCWrite, 1);
    step();
    funct3 = 3'b111;
    step();
    step();
    chk("bgeu_alu", ALUControl, 4'b0110);
    chk("bgeu_pcw", PCWrite, 0);
    step();

    // srai and addi with Instr[30] set
    opcode = 7'b0010011; funct3 = 3'b101; funct7b5 = 1'b1;
    step();
    step();
    chk("srai_alu", ALUControl, 4'b1001);
    chk("srai_srcb", ALUSrcB, 2'b01);
    step();
    step();
    funct3 = 3'b000;
    step();
    step();
    chk("addi_neg_alu", ALUControl, 4'b0000);
    step();
    step();

    // jalr / LINK
    set_instr(32'h000080E7);
    step();
    step();
    chk("jalr_pcw", PCWrite, 1);
    chk("jalr_lsb", JALR_LSB, 1);
    chk("jalr_res", ResultSrc, 2'b10);
    step();
    chk("link_rw", RegWrite, 1);
    chk("link_res", ResultSrc, 2'b10);
    chk("link_srcb", ALUSrcB, 2'b10);
    step();

    // jal target immediate and lui pass-through
    set_instr(32'h0000006F);
    step();
    chk("jal_dec_imm", ImmSrc, 3'b011);
    step();
    chk("jal_pcw", PCWrite, 1);
    chk("jal_srca", ALUSrcA, 2'b01);
    step();
    step();
    set_instr(32'h000000B7);
    step();
    step();
    chk("lui_alu", ALUControl, 4'b1010);
    chk("lui_imm", ImmSrc, 3'b100);
    step();
    step();

    // cycles per instruction
    count_cycles("cpi_lw", 32'h0080A283, 5);
    count_cycles("cpi_sw", 32'h0020A023, 4);
    count_cycles("cpi_addi", 32'h00100093, 4);
    count_cycles("cpi_beq", 32'h00208463, 3);
    count_cycles("cpi_jal", 32'h0000006F, 4);
    count_cycles("cpi_jalr", 32'h000080E7, 4);
    count_cycles("cpi_auipc", 32'h00000097, 4);

    // unsupported opcode
    set_instr(32'h00000000);
    step();
    step();
`ifdef ILLEGAL_HALT_EN
    for (int i = 0; i < 10; i++) begin
      chk("halt_illegal", illegal, 1);
      chk("halt_we", {IRWrite, RegWrite, MemWrite, PCWrite}, 4'b0000);
      step();
    end
    do_reset();
    chk("halt_cleared", illegal, 0);
`else
    chk("nohalt_illegal", illegal, 0);
    chk("nohalt_we", {IRWrite, RegWrite, MemWrite, PCWrite}, 4'b0000);
    step();
    chk("nohalt_fetch", IRWrite, 1);
`endif

    // async reset during MEMWRITE
    set_instr(32'h0020A023);
    step();
    step();
    chk("sw_imm", ImmSrc, 3'b001);
    step();
    chk("memwr_mw", MemWrite, 1);
    chk("memwr_addr", AddrSrc, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_mw", MemWrite, 0);
    chk("async_pcw", PCWrite, 0);
    step();
    chk("rsthold_we", {IRWrite, RegWrite, MemWrite, PCWrite}, 4'b0000);
    rst = 1'b0;
    #1;
    chk("post_rst_fetch", IRWrite, 1);
    step();
    chk("post_rst_dec", ALUSrcA, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have no parameters; all encodings come from the shared package.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 opcode  in  7  Instr[6:0] from the instruction register.
REQ-005 funct3  in  3  Instr[14:12]; funct7b5  in  1  Instr[30].
REQ-006 Zero  in  1  ALU zero flag.
REQ-007 ImmSrc  out  3  immediate format: I=000, S=001, B=010, J=011, U=100.
REQ-008 ALUControl  out  4  ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLT=0101, SLTU=0110, SLL=0111, SRL=1000, SRA=1001, PASSB=1010.
REQ-009 ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
REQ-010 ALUSrcA  out  2  00=PC, 01=OldPC, 10=A; ALUSrcB  out  2  00=WriteData, 01=ImmExt, 10=4.
REQ-011 IRWrite, RegWrite, MemWrite, PCWrite, AddrSrc (0=PC, 1=Result), JALR_LSB  out  1 each.
REQ-012 illegal  out  1  high while halted on an unsupported opcode.

Function
REQ-013 Moore FSM; outputs not listed for a state SHALL be 0, with ALUControl=ADD and ImmSrc=I.
REQ-014 FETCH: AddrSrc=0, IRWrite=1, A=PC, B=4, ADD, ResultSrc=10, PCWrite=1 -> DECODE.
REQ-015 DECODE: A=OldPC, B=Imm, ADD, ImmSrc=J for JAL, else B; next state by opcode: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 -> JAL, 1100111 -> JALR, 0110111 -> LUI, 0010111 -> AUIPC, other -> ILLEGAL.
REQ-016 MEMADR: A=A, B=Imm, ADD, ImmSrc=I (load) or S (store) -> MEMREAD (load) or MEMWRITE (store).
REQ-017 MEMREAD: AddrSrc=1, ResultSrc=00 -> MEMWB. MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
REQ-018 MEMWRITE: AddrSrc=1, ResultSrc=00, MemWrite=1 -> FETCH.
REQ-019 EXECR/EXECI: A=A, B=WriteData (R) or Imm/ImmSrc=I (I), ALUControl from alu decode -> ALUWB.
REQ-020 ALU decode: funct3 000 ADD, except SUB when R-type and funct7b5=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7b5=1 (R and I); 110 OR; 111 AND.
REQ-021 ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
REQ-022 BRANCH: A=A, B=WriteData, ResultSrc=00; funct3 000/001 SUB, 100/101 SLT, 110/111 SLTU; PCWrite=Zero for 000/101/111, PCWrite=~Zero for 001/100/110; funct3 010/011 -> ILLEGAL instead; -> FETCH.
REQ-023 JAL: A=OldPC, B=4, ADD, ResultSrc=00, PCWrite=1 (target from DECODE) -> ALUWB.
REQ-024 JALR: A=A, B=Imm, ImmSrc=I, ADD, JALR_LSB=1, ResultSrc=10, PCWrite=1 -> LINK. LINK: A=OldPC, B=4, ADD, ResultSrc=10, RegWrite=1 -> FETCH.
REQ-025 LUI: B=Imm, ImmSrc=U, PASSB -> ALUWB. AUIPC: A=OldPC, B=Imm, ImmSrc=U, ADD -> ALUWB.
REQ-026 Cycles per instruction: load 5, store 4, R/I 4, branch 3, JAL 4, JALR 4, LUI/AUIPC 4.
REQ-027 ILLEGAL: see Configuration.
REQ-028 Inputs SHALL be sampled only in states that use them; opcode changes outside DECODE SHALL have no effect.

Reset
REQ-029 rst=1 SHALL force FETCH immediately, irrespective of clk, including mid-instruction; no RegWrite, MemWrite or PCWrite pulse is issued while rst=1.
REQ-030 First rising edge after rst falls SHALL execute FETCH; illegal=0.

Configuration
REQ-031 With ILLEGAL_HALT_EN defined: ILLEGAL holds illegal=1 and all write enables at 0 until reset.
REQ-032 Without it: ILLEGAL is a one-cycle no-op -> FETCH, and illegal is tied 0.

Structure
REQ-033 Shared package ctrl_pkg: state enum, ImmSrc, ALUControl, ResultSrc, ALUSrcA/B encodings and opcode constants.
REQ-034 Sub-module alu_decoder (funct3, funct7b5, is_rtype -> ALUControl), combinational.

Verification
REQ-035 Reset, then opcode=0110011, funct3=000, funct7b5=1 -> FETCH, DECODE, EXECR (ALUControl=0001), ALUWB (RegWrite=1); FETCH again on cycle 5.
REQ-036 lw (0x0080A283) -> 5 cycles; MEMREAD AddrSrc=1; MEMWB ResultSrc=01, RegWrite=1; MemWrite=0 throughout.
REQ-037 beq (0x00208463) with Zero=1 -> PCWrite=1 in BRANCH; with Zero=0 -> PCWrite=0; bne inverts both.
REQ-038 jalr (0x000080E7) -> JALR: PCWrite=1, JALR_LSB=1; LINK: RegWrite=1, ResultSrc=10.
REQ-039 opcode=0000000 -> illegal=1, held for 10 cycles, no write enables (macro on); with macro off -> FETCH after 1 cycle.
REQ-040 rst asserted mid-cycle during MEMWRITE -> MemWrite drops to 0 immediately (asynchronous); FETCH after release.
